// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Registered ALU/EX control stage for the pipelined MIPS core. Decodes the ID
// stage funct/alu_op, captures the ALU select into the ID/EX boundary and
// sequences the multi-cycle mult/div unit (start pulse, busy window, HI/LO
// write strobe), stalling HI/LO-dependent instructions while it is busy.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   id_valid    ID stage holds a valid instruction
//   id_funct    instruction bits [5:0]
//   id_alu_op   main-control ALU op: 00 addi/mem, 01 branch, 10 R-type, 11 reserved
//   flush       squash the instruction entering EX
//   stall       combinational; ID holds, EX receives a bubble
//   ex_valid    EX holds a valid instruction
//   ex_sel      ALU select for EX
//   ex_hilo_rd  00 none, 01 MFHI, 10 MFLO
//   ex_illegal  EX instruction is an undecoded R-type funct or alu_op 11
//   md_start    one-cycle start pulse to the mult/div unit
//   md_is_div   valid with md_start: 1 = divide
//   md_signed   valid with md_start: 1 = MULT/DIV, 0 = MULTU/DIVU
//   md_busy     mult/div unit occupied
//   hilo_we     HI/LO write strobe, last busy cycle
//
// Mult/div FSM:
//   state   | meaning
//   ST_IDLE | mult/div unit free, cnt = 0
//   ST_BUSY | mult/div in flight, cnt = remaining busy cycles (1 = last, hilo_we)

module alu_exec_ctrl #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [5:0] id_funct,
   input  logic [1:0] id_alu_op,
   input  logic       flush,
   output logic       stall,
   output logic       ex_valid,
   output logic [2:0] ex_sel,
   output logic [1:0] ex_hilo_rd,
   output logic       ex_illegal,
   output logic       md_start,
   output logic       md_is_div,
   output logic       md_signed,
   output logic       md_busy,
   output logic       hilo_we
);

   localparam logic [2:0] SEL_AND  = 3'b000;
   localparam logic [2:0] SEL_OR   = 3'b001;
   localparam logic [2:0] SEL_ADD  = 3'b010;
   localparam logic [2:0] SEL_SLT  = 3'b011;
   localparam logic [2:0] SEL_ADDU = 3'b100;
   localparam logic [2:0] SEL_SLL  = 3'b101;
   localparam logic [2:0] SEL_SUB  = 3'b110;
   localparam logic [2:0] SEL_SLTU = 3'b111;

   localparam logic [1:0] HILO_NONE = 2'b00;
   localparam logic [1:0] HILO_HI   = 2'b01;
   localparam logic [1:0] HILO_LO   = 2'b10;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [2:0] dec_sel;
   logic [1:0] dec_hilo_rd;
   logic       dec_illegal;
   logic       dec_md;
   logic       dec_div;
   logic       dec_signed;
   logic       dec_dep;

   logic       cnt_last;
   logic       capture;
   logic       md_go;

   // ------------------------------------------------------------------
   // ID decode
   // ------------------------------------------------------------------
   always_comb begin
      dec_sel     = SEL_AND;
      dec_hilo_rd = HILO_NONE;
      dec_illegal = 1'b0;
      dec_md      = 1'b0;
      dec_div     = 1'b0;
      dec_signed  = 1'b0;
      case (id_alu_op)
         2'b00: dec_sel = SEL_ADD;
         2'b01: dec_sel = SEL_SUB;
         2'b10: begin
            case (id_funct)
               6'b100000: dec_sel = SEL_ADD;
               6'b100001: dec_sel = SEL_ADDU;
               6'b100010: dec_sel = SEL_SUB;
               6'b100011: dec_sel = SEL_SUB;
               6'b100100: dec_sel = SEL_AND;
               6'b100101: dec_sel = SEL_OR;
               6'b000000: dec_sel = SEL_SLL;
               6'b101010: dec_sel = SEL_SLT;
               6'b101011: dec_sel = SEL_SLTU;
               6'b011000: begin
                  dec_md     = 1'b1;
                  dec_signed = 1'b1;
               end
               6'b011001: dec_md = 1'b1;
               6'b011010: begin
                  dec_md     = 1'b1;
                  dec_div    = 1'b1;
                  dec_signed = 1'b1;
               end
               6'b011011: begin
                  dec_md  = 1'b1;
                  dec_div = 1'b1;
               end
               6'b010000: dec_hilo_rd = HILO_HI;
               6'b010010: dec_hilo_rd = HILO_LO;
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Anything that reads or rewrites HI/LO must wait for the unit.
   assign dec_dep  = dec_md || (dec_hilo_rd != HILO_NONE);
   assign cnt_last = (cnt == CNT_ONE);

   // In the hilo_we cycle the write lands on the same edge a dependent
   // instruction captures, so no stall is needed there.
   assign stall   = id_valid && md_busy && !cnt_last && dec_dep;
   assign capture = id_valid && !flush && !stall;
   assign md_go   = capture && dec_md;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (md_go) begin
               state_nxt = ST_BUSY;
               cnt_nxt   = dec_div ? DIV_LOAD : MULT_LOAD;
            end
         end
         ST_BUSY: begin
            if (cnt_last) begin
               // Back-to-back mult/div restarts directly from the last cycle.
               if (md_go) begin
                  state_nxt = ST_BUSY;
                  cnt_nxt   = dec_div ? DIV_LOAD : MULT_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      md_busy = 1'b0;
      hilo_we = 1'b0;
      if (state == ST_BUSY) begin
         md_busy = 1'b1;
         hilo_we = cnt_last;
      end
   end

   // ------------------------------------------------------------------
   // ID/EX boundary registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_sel     <= SEL_AND;
         ex_hilo_rd <= HILO_NONE;
         ex_illegal <= 1'b0;
         md_start   <= 1'b0;
         md_is_div  <= 1'b0;
         md_signed  <= 1'b0;
      end else if (capture) begin
         ex_valid   <= 1'b1;
         ex_sel     <= dec_sel;
         ex_hilo_rd <= dec_hilo_rd;
         ex_illegal <= dec_illegal;
         md_start   <= dec_md;
         md_is_div  <= dec_md && dec_div;
         md_signed  <= dec_md && dec_signed;
      end else begin
         ex_valid   <= 1'b0;
         ex_sel     <= SEL_AND;
         ex_hilo_rd <= HILO_NONE;
         ex_illegal <= 1'b0;
         md_start   <= 1'b0;
         md_is_div  <= 1'b0;
         md_signed  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
module tb_alu_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [5:0] id_funct;
   logic [1:0] id_alu_op;
   logic       flush;
   logic       stall;
   logic       ex_valid;
   logic [2:0] ex_sel;
   logic [1:0] ex_hilo_rd;
   logic       ex_illegal;
   logic       md_start;
   logic       md_is_div;
   logic       md_signed;
   logic       md_busy;
   logic       hilo_we;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   alu_exec_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_funct   (id_funct),
      .id_alu_op  (id_alu_op),
      .flush      (flush),
      .stall      (stall),
      .ex_valid   (ex_valid),
      .ex_sel     (ex_sel),
      .ex_hilo_rd (ex_hilo_rd),
      .ex_illegal (ex_illegal),
      .md_start   (md_start),
      .md_is_div  (md_is_div),
      .md_signed  (md_signed),
      .md_busy    (md_busy),
      .hilo_we    (hilo_we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
      id_valid  = v;
      id_alu_op = op;
      id_funct  = f;
   endtask

   logic [5:0] sweep_f   [9];
   logic [2:0] sweep_sel [9];
   logic       seen_we;

   initial begin
      sweep_f   = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLL, F_SLT, F_SLTU};
      sweep_sel = '{3'b010, 3'b100, 3'b110, 3'b110, 3'b000, 3'b001, 3'b101, 3'b011, 3'b111};

      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 2'b00, 6'd0);
      tick(); tick();
      chk("rst_ex_valid", {7'd0, ex_valid}, 8'd0);
      chk("rst_ex_sel",   {5'd0, ex_sel}, 8'd0);
      chk("rst_md_busy",  {7'd0, md_busy}, 8'd0);
      chk("rst_hilo_we",  {7'd0, hilo_we}, 8'd0);
      chk("rst_md_start", {7'd0, md_start}, 8'd0);
      rst = 1'b0;
      tick();

      // R-type sweep, back to back
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 2'b10, sweep_f[i]);
         tick();
         chk($sformatf("sweep_sel_%0d", i), {5'd0, ex_sel}, {5'd0, sweep_sel[i]});
         chk($sformatf("sweep_valid_%0d", i), {7'd0, ex_valid}, 8'd1);
      end
      drive(1'b1, 2'b00, 6'h3f);
      tick();
      chk("aluop00_sel", {5'd0, ex_sel}, 8'b010);
      chk("aluop00_ill", {7'd0, ex_illegal}, 8'd0);
      drive(1'b1, 2'b01, 6'h3f);
      tick();
      chk("aluop01_sel", {5'd0, ex_sel}, 8'b110);

      // MULT then MFLO
      drive(1'b1, 2'b10, F_MULT);
      tick();                                       // cycle 1
      chk("mult_c1_start",  {7'd0, md_start}, 8'd1);
      chk("mult_c1_signed", {7'd0, md_signed}, 8'd1);
      chk("mult_c1_isdiv",  {7'd0, md_is_div}, 8'd0);
      chk("mult_c1_busy",   {7'd0, md_busy}, 8'd1);
      chk("mult_c1_we",     {7'd0, hilo_we}, 8'd0);
      drive(1'b1, 2'b10, F_MFLO);
      #1;
      chk("mflo_c1_stall", {7'd0, stall}, 8'd1);
      tick();                                       // cycle 2
      chk("mult_c2_start", {7'd0, md_start}, 8'd0);
      chk("mflo_c2_stall", {7'd0, stall}, 8'd1);
      chk("mflo_c2_bubble", {7'd0, ex_valid}, 8'd0);
      tick();                                       // cycle 3
      chk("mflo_c3_stall", {7'd0, stall}, 8'd1);
      chk("mult_c3_we",    {7'd0, hilo_we}, 8'd0);
      tick();                                       // cycle 4
      chk("mult_c4_we",    {7'd0, hilo_we}, 8'd1);
      chk("mult_c4_busy",  {7'd0, md_busy}, 8'd1);
      chk("mflo_c4_stall", {7'd0, stall}, 8'd0);
      tick();                                       // cycle 5
      chk("mult_c5_busy", {7'd0, md_busy}, 8'd0);
      chk("mult_c5_we",   {7'd0, hilo_we}, 8'd0);
      chk("mflo_valid",   {7'd0, ex_valid}, 8'd1);
      chk("mflo_hilo_rd", {6'd0, ex_hilo_rd}, 8'b10);
      drive(1'b0, 2'b00, 6'd0);
      tick();

      // DIVU, ADD during busy, flush during busy
      drive(1'b1, 2'b10, F_DIVU);
      tick();                                       // cycle 1
      chk("divu_start",  {7'd0, md_start}, 8'd1);
      chk("divu_signed", {7'd0, md_signed}, 8'd0);
      chk("divu_isdiv",  {7'd0, md_is_div}, 8'd1);
      drive(1'b1, 2'b10, F_ADD);
      #1;
      chk("add_busy_stall", {7'd0, stall}, 8'd0);
      tick();                                       // cycle 2
      chk("add_busy_valid", {7'd0, ex_valid}, 8'd1);
      chk("add_busy_sel",   {5'd0, ex_sel}, 8'b010);
      flush = 1'b1;
      tick();                                       // cycle 3
      chk("flush_busy_bubble", {7'd0, ex_valid}, 8'd0);
      chk("flush_busy_stillbusy", {7'd0, md_busy}, 8'd1);
      flush = 1'b0;
      drive(1'b0, 2'b00, 6'd0);
      for (int c = 3; c < 31; c++) tick();          // cycle 31
      chk("divu_c31_we", {7'd0, hilo_we}, 8'd0);
      tick();                                       // cycle 32
      chk("divu_c32_we", {7'd0, hilo_we}, 8'd1);
      tick();                                       // cycle 33
      chk("divu_c33_busy", {7'd0, md_busy}, 8'd0);

      // Flush with MULT in ID
      drive(1'b1, 2'b10, F_MULT);
      flush = 1'b1;
      tick();
      chk("flush_mult_valid", {7'd0, ex_valid}, 8'd0);
      chk("flush_mult_start", {7'd0, md_start}, 8'd0);
      chk("flush_mult_busy",  {7'd0, md_busy}, 8'd0);
      flush = 1'b0;

      // Back-to-back MULT, MULT
      tick();                                       // cycle 1 of first
      drive(1'b1, 2'b10, F_MULTU);
      #1;
      chk("b2b_c1_stall", {7'd0, stall}, 8'd1);
      tick(); tick(); tick();                       // cycle 4
      chk("b2b_c4_we",    {7'd0, hilo_we}, 8'd1);
      chk("b2b_c4_stall", {7'd0, stall}, 8'd0);
      tick();                                       // cycle 1 of second
      chk("b2b_2nd_start", {7'd0, md_start}, 8'd1);
      chk("b2b_2nd_busy",  {7'd0, md_busy}, 8'd1);
      chk("b2b_2nd_we",    {7'd0, hilo_we}, 8'd0);
      drive(1'b0, 2'b00, 6'd0);
      tick(); tick(); tick();                       // cycle 4 of second
      chk("b2b_2nd_c4_we", {7'd0, hilo_we}, 8'd1);
      tick();

      // Illegal encodings
      drive(1'b1, 2'b10, 6'b111111);
      tick();
      chk("ill_funct_flag",  {7'd0, ex_illegal}, 8'd1);
      chk("ill_funct_sel",   {5'd0, ex_sel}, 8'd0);
      chk("ill_funct_start", {7'd0, md_start}, 8'd0);
      drive(1'b1, 2'b11, F_MULT);
      tick();
      chk("ill_op_flag",  {7'd0, ex_illegal}, 8'd1);
      chk("ill_op_sel",   {5'd0, ex_sel}, 8'd0);
      chk("ill_op_start", {7'd0, md_start}, 8'd0);
      chk("ill_op_busy",  {7'd0, md_busy}, 8'd0);

      // Async reset during DIV busy cycle 2
      drive(1'b1, 2'b10, F_DIV);
      tick();                                       // cycle 1
      chk("div_start", {7'd0, md_start}, 8'd1);
      drive(1'b1, 2'b10, F_ADD);
      tick();                                       // cycle 2
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy",  {7'd0, md_busy}, 8'd0);
      chk("arst_valid", {7'd0, ex_valid}, 8'd0);
      chk("arst_we",    {7'd0, hilo_we}, 8'd0);
      chk("arst_sel",   {5'd0, ex_sel}, 8'd0);
      drive(1'b0, 2'b00, 6'd0);
      tick();
      rst = 1'b0;
      seen_we = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         seen_we = seen_we | hilo_we;
      end
      chk("arst_no_we", {7'd0, seen_we}, 8'd0);
      drive(1'b1, 2'b10, F_MULTU);
      tick();                                       // cycle 1
      chk("multu_start",  {7'd0, md_start}, 8'd1);
      chk("multu_signed", {7'd0, md_signed}, 8'd0);
      chk("multu_isdiv",  {7'd0, md_is_div}, 8'd0);
      drive(1'b0, 2'b00, 6'd0);
      tick(); tick(); tick();                       // cycle 4
      chk("multu_c4_we", {7'd0, hilo_we}, 8'd1);
      tick();
      chk("multu_done", {7'd0, md_busy}, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
